// File: rtl/alu_pkg.sv
// Shared ALU select encodings and legality check for the
// ALU-sharing arbiter and the clients that drive it.
package alu_pkg;

  localparam int ALU_SEL_W = 4;

  localparam logic [ALU_SEL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_SEL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_SEL_W-1:0] ALU_OR  = 4'b0001;

  function automatic logic alu_sel_legal(
    input logic [ALU_SEL_W-1:0] sel
  );
    logic ok;
    case (sel)
      ALU_ADD, ALU_SUB,
      ALU_AND, ALU_OR: ok = 1'b1;
      default:         ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational ALU: add/sub/and/or on a 4-bit select.
// Unknown selects produce a zero result.
module alu_share_arbiter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]     in1_i,
  input  logic [WIDTH-1:0]     in2_i,
  input  logic [ALU_SEL_W-1:0] alu_sel_i,
  output logic [WIDTH-1:0]     result_o,
  output logic                 zero_o
);

  always_comb begin
    result_o = '0;
    case (alu_sel_i)
      ALU_ADD: result_o = in1_i + in2_i;
      ALU_SUB: result_o = in1_i - in2_i;
      ALU_AND: result_o = in1_i & in2_i;
      ALU_OR:  result_o = in1_i | in2_i;
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-client round-robin arbiter in front of one shared ALU,
// with a registered response slot per client.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [2*WIDTH-1:0]     req_in1,
  input  logic [2*WIDTH-1:0]     req_in2,
  input  logic [2*ALU_SEL_W-1:0] req_sel,
  output logic [1:0]             rsp_valid,
  input  logic [1:0]             rsp_ready,
  output logic [2*WIDTH-1:0]     rsp_result,
  output logic [1:0]             rsp_zero,
  output logic [1:0]             rsp_illegal,
  output logic [CNT_W-1:0]       ops_served
);

  logic [1:0]           free;
  logic [1:0]           elig;
  logic [1:0]           grant;
  logic                 gidx;
  logic [WIDTH-1:0]     a_m;
  logic [WIDTH-1:0]     b_m;
  logic [ALU_SEL_W-1:0] sel_m;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_zero;
  logic                 ill_m;

  logic [1:0]       vld_q, vld_d;
  logic [1:0]       zero_q, zero_d;
  logic [1:0]       ill_q, ill_d;
  logic [WIDTH-1:0] res_q [2];
  logic [WIDTH-1:0] res_d [2];
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A slot draining this cycle can accept a new result at the same edge
  assign free = ~vld_q | rsp_ready;
  assign elig = req_valid & free;

  always_comb begin
    grant = '0;
    unique case (1'b1)
      (elig == 2'b11): grant[rr_q] = 1'b1;
      (elig == 2'b01): grant[0]    = 1'b1;
      (elig == 2'b10): grant[1]    = 1'b1;
      default:         grant       = '0;
    endcase
  end

  assign gidx      = grant[1];
  assign req_ready = grant & {2{rst_n}};

  assign a_m   = gidx ? req_in1[WIDTH +: WIDTH]
                      : req_in1[0 +: WIDTH];
  assign b_m   = gidx ? req_in2[WIDTH +: WIDTH]
                      : req_in2[0 +: WIDTH];
  assign sel_m = gidx ? req_sel[ALU_SEL_W +: ALU_SEL_W]
                      : req_sel[0 +: ALU_SEL_W];
  assign ill_m = ~alu_sel_legal(sel_m);

  alu_share_arbiter_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .in1_i     (a_m),
    .in2_i     (b_m),
    .alu_sel_i (sel_m),
    .result_o  (alu_res),
    .zero_o    (alu_zero)
  );

  always_comb begin
    vld_d  = vld_q;
    zero_d = zero_q;
    ill_d  = ill_q;
    res_d  = res_q;
    rr_d   = rr_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (grant[i]) begin
        vld_d[i]  = 1'b1;
        res_d[i]  = alu_res;
        zero_d[i] = alu_zero;
        ill_d[i]  = ill_m;
      end else if (rsp_ready[i]) begin
        vld_d[i]  = 1'b0;
      end
    end
    if (|grant) begin
      rr_d = ~gidx;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      zero_q   <= '0;
      ill_q    <= '0;
      res_q[0] <= '0;
      res_q[1] <= '0;
      rr_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      vld_q    <= vld_d;
      zero_q   <= zero_d;
      ill_q    <= ill_d;
      res_q[0] <= res_d[0];
      res_q[1] <= res_d[1];
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rsp_valid   = vld_q;
  assign rsp_result  = {res_q[1], res_q[0]};
  assign rsp_zero    = zero_q;
  assign rsp_illegal = ill_q;
  assign ops_served  = cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: accepted requests push
// hand-computed results, a monitor pops them on consumption.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        il;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [63:0] req_in1 = '0;
  logic [63:0] req_in2 = '0;
  logic [7:0]  req_sel = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = '0;
  logic [63:0] rsp_result;
  logic [1:0]  rsp_zero;
  logic [1:0]  rsp_illegal;
  logic [15:0] ops_served;

  logic [1:0]  s_req_valid = '0;
  logic [1:0]  s_req_ready;
  logic [1:0]  s_rsp_valid;
  logic [63:0] s_rsp_result;
  logic [1:0]  s_rsp_zero;
  logic [1:0]  s_rsp_illegal;
  logic [1:0]  s_ops;

  exp_t pend0, pend1;
  exp_t q0[$];
  exp_t q1[$];
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_illegal(rsp_illegal), .ops_served(ops_served)
  );

  alu_share_arbiter #(.WIDTH(32), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_in1(64'h0), .req_in2(64'h0), .req_sel(8'h00),
    .rsp_valid(s_rsp_valid), .rsp_ready(2'b11),
    .rsp_result(s_rsp_result), .rsp_zero(s_rsp_zero),
    .rsp_illegal(s_rsp_illegal), .ops_served(s_ops)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic setreq(input int i,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] s, input logic [31:0] r,
                        input logic z, input logic il);
    if (i == 0) begin
      req_in1[31:0] = a; req_in2[31:0] = b; req_sel[3:0] = s;
      pend0 = {r, z, il};
    end else begin
      req_in1[63:32] = a; req_in2[63:32] = b; req_sel[7:4] = s;
      pend1 = {r, z, il};
    end
  endtask

  task automatic issue(input int i,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] s, input logic [31:0] r,
                       input logic z, input logic il);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    setreq(i, a, b, s, r, z, il);
    req_valid[i] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("issue_accept", 64'(ok), 64'd1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  // Acceptor: record expected result at each completed request handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_valid[0] && req_ready[0]) q0.push_back(pend0);
      if (req_valid[1] && req_ready[1]) q1.push_back(pend1);
    end
  end

  // Monitor: compare a response when it is consumed
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (rsp_valid[0] && rsp_ready[0]) begin
        if (q0.size() == 0) chk("rsp0_unexpected", 64'd1, 64'd0);
        else begin
          e = q0.pop_front();
          chk("rsp0_result", 64'(rsp_result[31:0]), 64'(e.r));
          chk("rsp0_zero", 64'(rsp_zero[0]), 64'(e.z));
          chk("rsp0_illegal", 64'(rsp_illegal[0]), 64'(e.il));
        end
      end
      if (rsp_valid[1] && rsp_ready[1]) begin
        if (q1.size() == 0) chk("rsp1_unexpected", 64'd1, 64'd0);
        else begin
          e = q1.pop_front();
          chk("rsp1_result", 64'(rsp_result[63:32]), 64'(e.r));
          chk("rsp1_zero", 64'(rsp_zero[1]), 64'(e.z));
          chk("rsp1_illegal", 64'(rsp_illegal[1]), 64'(e.il));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, req_ready held low even with requests pending
    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_result", rsp_result, 64'd0);
    chk("rst_ops", 64'(ops_served), 64'd0);
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single add with held response
    @(posedge clk); #1;
    setreq(0, 32'd5, 32'd7, ALU_ADD, 32'd12, 1'b0, 1'b0);
    req_valid = 2'b01;
    @(negedge clk);
    chk("add_ready", 64'(req_ready), 64'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("add_rsp_valid", 64'(rsp_valid), 64'b01);
    chk("add_result", 64'(rsp_result[31:0]), 64'd12);
    chk("add_zero", 64'(rsp_zero[0]), 64'd0);
    chk("add_ops", 64'(ops_served), 64'd1);
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    @(posedge clk); #1;
    @(negedge clk);
    chk("add_drained", 64'(rsp_valid), 64'd0);

    // Edge arithmetic and illegal select
    issue(0, 32'hFFFF_FFFF, 32'd1, ALU_ADD, 32'd0, 1'b1, 1'b0);
    issue(1, 32'd0, 32'd1, ALU_SUB, 32'hFFFF_FFFF, 1'b0, 1'b0);
    issue(0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_AND,
          32'h00F0_00F0, 1'b0, 1'b0);
    issue(1, 32'd7, 32'd8, 4'b1111, 32'd0, 1'b1, 1'b1);
    issue(0, 32'h10, 32'h01, ALU_OR, 32'h11, 1'b0, 1'b0);
    @(negedge clk);
    chk("edge_ops", 64'(ops_served), 64'd6);

    // Fill both slots, then reset asynchronously mid-cycle
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    setreq(0, 32'd1, 32'd1, ALU_ADD, 32'd2, 1'b0, 1'b0);
    setreq(1, 32'd3, 32'd1, ALU_SUB, 32'd2, 1'b0, 1'b0);
    req_valid = 2'b11;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("full_rsp_valid", 64'(rsp_valid), 64'b11);
    chk("full_ops", 64'(ops_served), 64'd8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_result", rsp_result, 64'd0);
    chk("midrst_flags", 64'({rsp_zero, rsp_illegal}), 64'd0);
    chk("midrst_ops", 64'(ops_served), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    q0.delete();
    q1.delete();
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Contention from rr=0: grants alternate 0,1,0,1
    @(posedge clk); #1;
    setreq(0, 32'd1, 32'd2, ALU_ADD, 32'd3, 1'b0, 1'b0);
    setreq(1, 32'd9, 32'd9, ALU_SUB, 32'd0, 1'b1, 1'b0);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("cont_grant", 64'(req_ready), (k % 2 == 0) ? 64'b01 : 64'b10);
      chk("cont_ops", 64'(ops_served), 64'(k));
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    @(negedge clk);
    chk("cont_ops_end", 64'(ops_served), 64'd4);

    // Backpressure on slot 0 while slot 1 keeps flowing
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    issue(0, 32'hF, 32'h3, ALU_AND, 32'h3, 1'b0, 1'b0);
    setreq(0, 32'h20, 32'h02, ALU_OR, 32'h22, 1'b0, 1'b0);
    setreq(1, 32'd2, 32'd3, ALU_ADD, 32'd5, 1'b0, 1'b0);
    rsp_ready = 2'b10;
    req_valid = 2'b11;
    @(negedge clk);
    chk("bp_grant1", 64'(req_ready), 64'b10);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("bp_blocked", 64'(req_ready), 64'b00);
      chk("bp_held", 64'(rsp_result[31:0]), 64'h3);
      chk("bp_valid0", 64'(rsp_valid[0]), 64'd1);
      @(posedge clk); #1;
    end
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("bp_regrant", 64'(req_ready), 64'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("bp_reload", 64'(rsp_result[31:0]), 64'h22);
    chk("bp_ops", 64'(ops_served), 64'd7);

    // Saturating counter on the CNT_W=2 instance
    @(posedge clk); #1;
    s_req_valid = 2'b01;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      chk("sat_ops", 64'(s_ops), (k > 3) ? 64'd3 : 64'(k));
      @(posedge clk); #1;
    end
    s_req_valid = 2'b00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("q0_empty", 64'(q0.size()), 64'd0);
    chk("q1_empty", 64'(q1.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
